// File: rtl/avalon_pkg.sv
// Shared types and helpers for the Avalon-MM register bridge.
package avalon_pkg;

  typedef enum logic [1:0] {
    RSP_OKAY        = 2'b00,
    RSP_RESERVED    = 2'b01,
    RSP_SLAVEERROR  = 2'b10,
    RSP_DECODEERROR = 2'b11
  } avalon_resp_t;

  // Address width that never collapses to zero for a single-register bank.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avalon_delay_line.sv
// Fixed-depth shift register with asynchronous clear, used for the read response path.
module avalon_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/avalon_register_bridge.sv
// Avalon-MM slave fronting a bank of REGS registers: byte-enabled writes, read strobes,
// decode errors, pipelined read responses and a saturating protocol-error counter.
module avalon_register_bridge
  import avalon_pkg::*;
#(
  parameter int REGS       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int ADDR_W     = clog2_min1(REGS),
  parameter int ERRCNT_W   = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_W-1:0]                   avs_address,
  input  logic                                avs_read,
  input  logic                                avs_write,
  input  logic [DATA_WIDTH-1:0]               avs_writedata,
  input  logic [DATA_WIDTH/8-1:0]             avs_byteenable,
  output logic                                avs_waitrequest,
  output logic [DATA_WIDTH-1:0]               avs_readdata,
  output logic                                avs_readdatavalid,
  output logic [1:0]                          avs_response,
  input  logic                                reg_busy,
  output logic [REGS-1:0]                     reg_write_en,
  output logic [REGS-1:0]                     reg_read_en,
  output logic [DATA_WIDTH-1:0]               reg_wdata,
  output logic [DATA_WIDTH/8-1:0]             reg_byteen,
  input  logic [REGS-1:0][DATA_WIDTH-1:0]     reg_rdata,
  output logic [ERRCNT_W-1:0]                 err_count
);

  localparam int LINE_W = 1 + 2 + DATA_WIDTH;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + ERRCNT_W'(1);
  endfunction

  logic                  accept;
  logic                  vld_p0;
  logic                  rd_p0;
  logic                  wr_p0;
  logic [ADDR_W-1:0]     addr_p0;
  logic [REGS-1:0]       sel_p0;
  logic [DATA_WIDTH-1:0] rdata_sel_p0;
  logic                  in_range_p0;
  logic                  rd_ok_p0;
  logic                  err_p0;
  avalon_resp_t          resp_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [LINE_W-1:0]     line_in;
  logic [LINE_W-1:0]     line_out;

  assign avs_waitrequest = reset | reg_busy;
  assign accept          = (avs_read | avs_write) & ~avs_waitrequest;

  // ---- stage p0: registered command, drives the enable cycle ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      rd_p0      <= 1'b0;
      wr_p0      <= 1'b0;
      addr_p0    <= '0;
      reg_wdata  <= '0;
      reg_byteen <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        rd_p0      <= avs_read;
        wr_p0      <= avs_write;
        addr_p0    <= avs_address;
        reg_wdata  <= avs_writedata;
        reg_byteen <= avs_byteenable;
      end
    end
  end

  always_comb begin
    sel_p0       = '0;
    rdata_sel_p0 = '0;
    for (int i = 0; i < REGS; i++) begin
      if (32'(addr_p0) == i) begin
        sel_p0[i]    = 1'b1;
        rdata_sel_p0 = reg_rdata[i];
      end
    end
  end

  // A read issued together with a write is dropped; the write still goes through.
  assign in_range_p0  = |sel_p0;
  assign rd_ok_p0     = vld_p0 & rd_p0 & ~wr_p0;
  assign err_p0       = vld_p0 & ((rd_p0 & wr_p0) | ~in_range_p0);
  assign reg_write_en = (vld_p0 & wr_p0 & in_range_p0 & (|reg_byteen)) ? sel_p0 : '0;
  assign reg_read_en  = (rd_ok_p0 & in_range_p0) ? sel_p0 : '0;
  assign resp_p0      = (rd_ok_p0 & ~in_range_p0) ? RSP_DECODEERROR : RSP_OKAY;
  assign data_p0      = (rd_ok_p0 & in_range_p0) ? rdata_sel_p0 : '0;
  assign line_in      = {rd_ok_p0, resp_p0, data_p0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_count <= '0;
    else if (err_p0) err_count <= sat_inc(err_count);
  end

  // ---- stages p1..pLATENCY: read response shift line ----
  avalon_delay_line #(
    .WIDTH (LINE_W),
    .DEPTH (LATENCY)
  ) u_read_line (
    .clk   (clk),
    .reset (reset),
    .din   (line_in),
    .dout  (line_out)
  );

  assign avs_readdatavalid = line_out[LINE_W-1];
  assign avs_response      = line_out[DATA_WIDTH+1:DATA_WIDTH];
  assign avs_readdata      = line_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_avalon_register_bridge.sv
// Bench for avalon_register_bridge: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_avalon_register_bridge;
  import avalon_pkg::*;

  localparam int REGS = 3;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int EW   = 3;
  localparam int AW   = 2;
  localparam int BW   = DW/8;
  localparam int EMAX = (1 << EW) - 1;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [AW-1:0]             avs_address = '0;
  logic                      avs_read = 1'b0;
  logic                      avs_write = 1'b0;
  logic [DW-1:0]             avs_writedata = '0;
  logic [BW-1:0]             avs_byteenable = '0;
  logic                      avs_waitrequest;
  logic [DW-1:0]             avs_readdata;
  logic                      avs_readdatavalid;
  logic [1:0]                avs_response;
  logic                      reg_busy = 1'b0;
  logic [REGS-1:0]           reg_write_en;
  logic [REGS-1:0]           reg_read_en;
  logic [DW-1:0]             reg_wdata;
  logic [BW-1:0]             reg_byteen;
  logic [REGS-1:0][DW-1:0]   reg_rdata;
  logic [EW-1:0]             err_count;

  always #5 clk = ~clk;

  avalon_register_bridge #(
    .REGS       (REGS),
    .DATA_WIDTH (DW),
    .LATENCY    (LAT),
    .ERRCNT_W   (EW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_response      (avs_response),
    .reg_busy          (reg_busy),
    .reg_write_en      (reg_write_en),
    .reg_read_en       (reg_read_en),
    .reg_wdata         (reg_wdata),
    .reg_byteen        (reg_byteen),
    .reg_rdata         (reg_rdata),
    .err_count         (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what was accepted at each edge, and the responses owed.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rsp_t;

  rsp_t          rq[$];
  int            cyc = 0;
  int            err_m = 0;
  logic          acc = 1'b0;
  logic          a_rd = 1'b0;
  logic          a_wr = 1'b0;
  int            a_addr = 0;
  logic [DW-1:0] a_wd = '0;
  logic [BW-1:0] a_be = '0;

  always @(posedge clk) begin
    cyc++;
    acc    = (avs_read || avs_write) && !reset && !reg_busy;
    a_rd   = avs_read;
    a_wr   = avs_write;
    a_addr = int'(avs_address);
    a_wd   = avs_writedata;
    a_be   = avs_byteenable;
  end

  always @(negedge clk) begin
    logic [REGS-1:0] ew;
    logic [REGS-1:0] er;
    rsp_t            e;
    if (reset) begin
      rq.delete();
      err_m = 0;
      chk("rst_waitrequest", avs_waitrequest, 1);
      chk("rst_readdatavalid", avs_readdatavalid, 0);
      chk("rst_readdata", avs_readdata, 0);
      chk("rst_response", avs_response, 0);
      chk("rst_write_en", reg_write_en, 0);
      chk("rst_read_en", reg_read_en, 0);
      chk("rst_wdata", reg_wdata, 0);
      chk("rst_byteen", reg_byteen, 0);
      chk("rst_err_count", err_count, 0);
    end else begin
      ew = '0;
      er = '0;
      if (acc && a_wr && a_addr < REGS && a_be != 0) ew[a_addr] = 1'b1;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        chk("m_readdatavalid", avs_readdatavalid, 1);
        chk("m_readdata", avs_readdata, rq[0].data);
        chk("m_response", avs_response, rq[0].resp);
        void'(rq.pop_front());
      end else begin
        chk("m_readdatavalid_idle", avs_readdatavalid, 0);
      end
      if (acc && a_rd && !a_wr) begin
        e.due = cyc + LAT;
        if (a_addr < REGS) begin
          er[a_addr] = 1'b1;
          e.data = reg_rdata[a_addr];
          e.resp = 2'b00;
        end else begin
          e.data = '0;
          e.resp = 2'b11;
        end
        rq.push_back(e);
      end
      chk("m_waitrequest", avs_waitrequest, reg_busy);
      chk("m_write_en", reg_write_en, ew);
      chk("m_read_en", reg_read_en, er);
      if (acc && a_wr) begin
        chk("m_wdata", reg_wdata, a_wd);
        chk("m_byteen", reg_byteen, a_be);
      end
      chk("m_err_count", err_count, err_m);
      if (acc && ((a_rd && a_wr) || a_addr >= REGS))
        err_m = (err_m == EMAX) ? EMAX : err_m + 1;
    end
  end

  task automatic drive(input logic rd, input logic wr, input int addr,
                       input logic [DW-1:0] wd, input logic [BW-1:0] be);
    avs_read       = rd;
    avs_write      = wr;
    avs_address    = AW'(addr);
    avs_writedata  = wd;
    avs_byteenable = be;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, '0, '0);
  endtask

  task automatic wait_rdv(input int budget, output int n, output logic ok);
    ok = 1'b0;
    n  = 0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (avs_readdatavalid) ok = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] rv [REGS];
  int            n;
  logic          ok;

  initial begin
    rv[0] = 32'hA0A0_0001;
    rv[1] = 32'hB1B1_0002;
    rv[2] = 32'hC2C2_0003;
    for (int i = 0; i < REGS; i++) reg_rdata[i] = rv[i];

    repeat (3) @(negedge clk);
    chk("reset_waitrequest", avs_waitrequest, 1);
    chk("reset_err_count", err_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // back-to-back reads return in issue order, first one LATENCY+1 cycles after issue
    drive(1'b1, 1'b0, 0, '0, '1); step();
    drive(1'b1, 1'b0, 1, '0, '1); step();
    drive(1'b1, 1'b0, 2, '0, '1); step();
    idle();
    for (int k = 0; k < 3; k++) begin
      wait_rdv(4, n, ok);
      chk("b2b_timeout", ok, 1);
      chk("b2b_gap", n, 1);
      chk("b2b_data", avs_readdata, rv[k]);
      chk("b2b_resp", avs_response, 2'b00);
    end

    // partial write
    drive(1'b0, 1'b1, 2, 32'hDEADBEEF, 4'b0101); step();
    idle();
    @(negedge clk);
    chk("pw_write_en", reg_write_en, 3'b100);
    chk("pw_wdata", reg_wdata, 32'hDEADBEEF);
    chk("pw_byteen", reg_byteen, 4'b0101);
    chk("pw_read_en", reg_read_en, 0);

    // stall: command held while busy, accepted once released
    reg_busy = 1'b1;
    drive(1'b1, 1'b0, 1, '0, '1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_waitrequest", avs_waitrequest, 1);
      chk("stall_read_en", reg_read_en, 0);
    end
    @(posedge clk);
    #1 reg_busy = 1'b0;
    step();
    idle();
    wait_rdv(6, n, ok);
    chk("stall_timeout", ok, 1);
    chk("stall_latency", n, 3);
    chk("stall_data", avs_readdata, rv[1]);

    // decode error read
    drive(1'b1, 1'b0, 3, '0, '1); step();
    idle();
    @(negedge clk);
    chk("dec_read_en", reg_read_en, 0);
    wait_rdv(4, n, ok);
    chk("dec_timeout", ok, 1);
    chk("dec_latency", n, 2);
    chk("dec_data", avs_readdata, 0);
    chk("dec_resp", avs_response, 2'b11);
    chk("dec_err_count", err_count, 1);

    // simultaneous read and write: only the write happens
    drive(1'b1, 1'b1, 1, 32'h1234_5678, 4'hF); step();
    idle();
    @(negedge clk);
    chk("rw_write_en", reg_write_en, 3'b010);
    chk("rw_read_en", reg_read_en, 0);
    @(negedge clk);
    chk("rw_err_count", err_count, 2);

    // six more errors saturate a 3-bit counter at 7
    repeat (6) begin
      drive(1'b0, 1'b1, 3, $urandom, 4'hF);
      step();
    end
    idle();
    repeat (2) @(negedge clk);
    chk("sat_err_count", err_count, 7);

    // reset while a read is in flight
    drive(1'b1, 1'b0, 0, '0, '1); step();
    idle();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_waitrequest", avs_waitrequest, 1);
    chk("mid_rst_readdatavalid", avs_readdatavalid, 0);
    chk("mid_rst_err_count", err_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_rdv(5, n, ok);
    chk("post_rst_no_rdv", ok, 0);
    drive(1'b1, 1'b0, 0, '0, '1); step();
    idle();
    wait_rdv(6, n, ok);
    chk("post_rst_timeout", ok, 1);
    chk("post_rst_latency", n, 3);
    chk("post_rst_data", avs_readdata, rv[0]);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      drive(sel < 4, (sel >= 4 && sel < 7) || sel == 7, $urandom_range(0, 3),
            $urandom, BW'($urandom_range(0, 15)));
      reg_busy = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      for (int r = 0; r < REGS; r++)
        if ($urandom_range(0, 9) == 0) reg_rdata[r] = $urandom;
      step();
    end
    idle();
    reg_busy = 1'b0;
    reset    = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("drain_pending", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
